uart_frame_rx: RTL and testbench
================================

# uart_frame_rx

Receive-side frame parser for the UART string link. Consumes bytes from the `uart_rx` byte receiver and strips the `&&data&&` framing. Presents the payload as a packed string with a length, a done pulse, and error reporting for overflow and inter-byte timeout. Sits between `uart_rx` and the command/application logic, mirroring the framing produced by the transmit-side string handler.

## Interface

Parameters:
- `MAX_LEN`, 137: payload capacity in bytes. Must be ≤ 255 and ≤ 137 so the payload fits in 1096 bits.
- `TIMEOUT_CLK`, 500_000: inter-byte timeout in `sys_clk` cycles, applied while inside a frame.

Ports:
- `sys_clk`, input, 1: clock.
- `sys_rst_n`, input, 1: reset, asynchronous, active-low. Clock is `sys_clk`.
- `rx_byte`, input, 8: byte from `uart_rx`. Valid only when `rx_vld` is high.
- `rx_vld`, input, 1: one-cycle strobe, one byte per pulse.
- `rx_string`, output, 1096: payload. Byte k sits at `[8k+7:8k]`. Unused bytes are 0.
- `rx_length`, output, 8: payload byte count.
- `rx_busy`, output, 1: high while inside a frame (states SIGN1, CONTENT, END1).
- `rx_done`, output, 1: one-cycle pulse when a frame completes.
- `rx_err`, output, 1: one-cycle pulse when a frame is aborted.
- `err_code`, output, 2: cause of the last abort. 01 = overflow, 10 = timeout, 00 = none.

## Operation

- States: IDLE, SIGN1, CONTENT, END1. All transitions are evaluated only on `rx_vld` or on timeout.
- IDLE:
  - `&` → SIGN1.
  - Any other byte is discarded; stay in IDLE.
- SIGN1:
  - `&` → CONTENT. On this same edge, clear `rx_string` to 0, `rx_length` to 0, and `err_code` to 00.
  - Any other byte → IDLE, with no error.
- CONTENT:
  - Non-`&` byte: write it to byte slot `rx_length` and increment `rx_length`.
  - `&` → END1. Nothing is stored.
- END1:
  - `&` → IDLE and pulse `rx_done`.
  - Non-`&` byte: this was an embedded single `&`. Store `&` at slot `rx_length` and the new byte at slot `rx_length+1`, add 2 to `rx_length`, → CONTENT.
- Overflow: a store that would write slot ≥ `MAX_LEN` aborts the frame.
  - Pulse `rx_err`, set `err_code` = 01, → IDLE.
  - No partial write of the out-of-range byte.
  - In END1, if only one slot remains, neither byte is written.
- Empty frame `&&&&`: `rx_done` with `rx_length` = 0.
- `rx_string` and `rx_length` hold their values after `rx_done` or `rx_err` until the next SIGN1→CONTENT transition.
- Byte values are compared as ASCII `&` = 8'h26. All other values, including 8'h00, are payload.

## Timing

- Reset values:
  - state = IDLE.
  - `rx_string` = 0, `rx_length` = 0.
  - `rx_busy` = 0, `rx_done` = 0, `rx_err` = 0.
  - `err_code` = 00.
  - timeout counter = 0.
- All outputs are registered.
- Latency:
  - `rx_done` and `rx_err` rise on the clock edge that samples the terminating `rx_vld`, so they are visible the next cycle.
  - `rx_length` and `rx_string` are already final when `rx_done` is high.
- `rx_busy` rises on the edge that samples the first `&`. It falls on the same edge that raises `rx_done` or `rx_err`.
- Timeout counter:
  - Clears on every `rx_vld` and in IDLE.
  - Increments each cycle in SIGN1, CONTENT and END1.
  - On reaching `TIMEOUT_CLK-1`:
    - In SIGN1: silent return to IDLE.
    - In CONTENT or END1: pulse `rx_err`, set `err_code` = 10, → IDLE.
- Simultaneous `rx_vld` and timeout terminal count: the byte wins. It is processed and the counter clears.
- Back-to-back frames: `&` arriving the cycle after `rx_done` is accepted. IDLE → SIGN1 needs no gap.
- Asynchronous reset mid-frame forces all reset values immediately. No `rx_done` or `rx_err` pulse is issued.

## Test plan

- Send `&&ABC&&` with 2-cycle gaps between bytes → one `rx_done`; `rx_length` = 3; `rx_string[23:0]` = 24'h434241; upper bits 0; `rx_busy` high from the first `&` until `rx_done`.
- Send `xy&&A&B&&` → junk ignored; `rx_done`; `rx_length` = 3; bytes = `A`, `&`, `B` (8'h41, 8'h26, 8'h42).
- Send `&&&&`, then `&&Z&&` on the cycle after `rx_done` → two `rx_done` pulses; lengths 0 then 1; second payload is 8'h5A.
- With `MAX_LEN` = 4, send `&&ABCDE&&` → `rx_err` pulse on `E` with `err_code` = 01; `rx_length` = 4; trailing `&&` leaves the block in SIGN1 and then CONTENT without a spurious `rx_done`.
- With `TIMEOUT_CLK` = 100, send `&&AB` then idle for 100 cycles → `rx_err` with `err_code` = 10; `rx_length` = 2. A second case with `&` then idle → silent return to IDLE with no `rx_err`.
- Assert `sys_rst_n` low during CONTENT after `&&AB` → all outputs 0 immediately; a subsequent `&&Q&&` gives `rx_length` = 1 and payload 8'h51.

Source files
------------

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: receive-side frame parser for the UART string link.
// Strips the "&&data&&" framing from bytes produced by uart_rx. An embedded
// single '&' followed by any other byte is kept as payload.
//
// Ports:
//   sys_clk    - clock
//   sys_rst_n  - asynchronous active-low reset
//   rx_byte    - received byte, qualified by rx_vld
//   rx_vld     - one-cycle strobe, one byte per pulse
//   rx_string  - payload, byte k at [8k+7:8k], unused bytes 0
//   rx_length  - payload byte count
//   rx_busy    - high while inside a frame
//   rx_done    - one-cycle pulse on frame completion
//   rx_err     - one-cycle pulse on frame abort
//   err_code   - cause of last abort: 01 overflow, 10 timeout, 00 none
module uart_frame_rx #(
   parameter int unsigned MAX_LEN     = 137,
   parameter int unsigned TIMEOUT_CLK = 500_000
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic [7:0]    rx_byte,
   input  logic          rx_vld,
   output logic [1095:0] rx_string,
   output logic [7:0]    rx_length,
   output logic          rx_busy,
   output logic          rx_done,
   output logic          rx_err,
   output logic [1:0]    err_code
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CLK + 1);
   localparam logic [7:0]  Amp  = 8'h26;

   typedef enum logic [1:0] {StIdle, StSign1, StContent, StEnd1} state_e;

   state_e          state_q, state_d;
   logic [1095:0]   rx_string_q, rx_string_d;
   logic [7:0]      rx_length_q, rx_length_d;
   logic            rx_busy_q, rx_busy_d;
   logic            rx_done_q, rx_done_d;
   logic            rx_err_q, rx_err_d;
   logic [1:0]      err_code_q, err_code_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic       timeout;
   logic       is_amp;
   logic [7:0] len_p1;

   assign is_amp  = (rx_byte == Amp);
   assign len_p1  = rx_length_q + 8'd1;
   assign timeout = (state_q != StIdle) && (cnt_q == CntW'(TIMEOUT_CLK - 1));

   always_comb begin
      state_d     = state_q;
      rx_string_d = rx_string_q;
      rx_length_d = rx_length_q;
      err_code_d  = err_code_q;
      rx_done_d   = 1'b0;
      rx_err_d    = 1'b0;
      cnt_d       = (state_q == StIdle) ? '0 : cnt_q + CntW'(1);

      if (rx_vld) begin
         // A byte always wins over a simultaneous terminal count.
         cnt_d = '0;
         unique case (state_q)
            StIdle: begin
               if (is_amp) state_d = StSign1;
            end
            StSign1: begin
               if (is_amp) begin
                  state_d     = StContent;
                  rx_string_d = '0;
                  rx_length_d = '0;
                  err_code_d  = 2'b00;
               end else begin
                  state_d = StIdle;
               end
            end
            StContent: begin
               if (is_amp) begin
                  state_d = StEnd1;
               end else if ({1'b0, rx_length_q} >= 9'(MAX_LEN)) begin
                  state_d    = StIdle;
                  rx_err_d   = 1'b1;
                  err_code_d = 2'b01;
               end else begin
                  rx_string_d[{rx_length_q, 3'b000} +: 8] = rx_byte;
                  rx_length_d = len_p1;
               end
            end
            StEnd1: begin
               if (is_amp) begin
                  state_d   = StIdle;
                  rx_done_d = 1'b1;
               end else if (({1'b0, rx_length_q} + 9'd2) > 9'(MAX_LEN)) begin
                  // Both the deferred '&' and the new byte must fit, or neither is stored.
                  state_d    = StIdle;
                  rx_err_d   = 1'b1;
                  err_code_d = 2'b01;
               end else begin
                  rx_string_d[{rx_length_q, 3'b000} +: 8] = Amp;
                  rx_string_d[{len_p1, 3'b000} +: 8]      = rx_byte;
                  rx_length_d = rx_length_q + 8'd2;
                  state_d     = StContent;
               end
            end
         endcase
      end else if (timeout) begin
         state_d = StIdle;
         // Timeout before the frame opened is silent.
         if (state_q != StSign1) begin
            rx_err_d   = 1'b1;
            err_code_d = 2'b10;
         end
      end

      rx_busy_d = (state_d != StIdle);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= StIdle;
         rx_string_q <= '0;
         rx_length_q <= '0;
         rx_busy_q   <= 1'b0;
         rx_done_q   <= 1'b0;
         rx_err_q    <= 1'b0;
         err_code_q  <= 2'b00;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         rx_string_q <= rx_string_d;
         rx_length_q <= rx_length_d;
         rx_busy_q   <= rx_busy_d;
         rx_done_q   <= rx_done_d;
         rx_err_q    <= rx_err_d;
         err_code_q  <= err_code_d;
         cnt_q       <= cnt_d;
      end
   end

   assign rx_string = rx_string_q;
   assign rx_length = rx_length_q;
   assign rx_busy   = rx_busy_q;
   assign rx_done   = rx_done_q;
   assign rx_err    = rx_err_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx with MAX_LEN=4 and TIMEOUT_CLK=100.
module tb_uart_frame_rx;

   logic          sys_clk;
   logic          sys_rst_n;
   logic [7:0]    rx_byte;
   logic          rx_vld;
   logic [1095:0] rx_string;
   logic [7:0]    rx_length;
   logic          rx_busy;
   logic          rx_done;
   logic          rx_err;
   logic [1:0]    err_code;

   int checks;
   int failures;
   int done_cnt;
   int err_cnt;
   int done_len [0:7];
   logic [1095:0] done_str [0:7];

   uart_frame_rx #(
      .MAX_LEN     (4),
      .TIMEOUT_CLK (100)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .rx_byte   (rx_byte),
      .rx_vld    (rx_vld),
      .rx_string (rx_string),
      .rx_length (rx_length),
      .rx_busy   (rx_busy),
      .rx_done   (rx_done),
      .rx_err    (rx_err),
      .err_code  (err_code)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Pulse monitor, sampled on the inactive edge.
   always @(negedge sys_clk) begin
      if (rx_done) begin
         if (done_cnt < 8) begin
            done_len[done_cnt] = int'(rx_length);
            done_str[done_cnt] = rx_string;
         end
         done_cnt = done_cnt + 1;
      end
      if (rx_err) err_cnt = err_cnt + 1;
   end

   task automatic do_reset();
      rx_vld    = 1'b0;
      rx_byte   = 8'h00;
      sys_rst_n = 1'b0;
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge sys_clk);
      rx_byte = b;
      rx_vld  = 1'b1;
      @(negedge sys_clk);
      rx_vld  = 1'b0;
      repeat (gap) @(negedge sys_clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (rx_string !== '0) begin failures++;
         $display("FAIL reset_string got %0h exp 0", rx_string[63:0]); end
      checks++; if (rx_length !== 8'd0) begin failures++;
         $display("FAIL reset_length got %0d exp 0", rx_length); end
      checks++; if (rx_busy !== 1'b0) begin failures++;
         $display("FAIL reset_busy got %b exp 0", rx_busy); end
      checks++; if (rx_done !== 1'b0 || rx_err !== 1'b0) begin failures++;
         $display("FAIL reset_pulses got done=%b err=%b exp 0 0", rx_done, rx_err); end
      checks++; if (err_code !== 2'b00) begin failures++;
         $display("FAIL reset_err_code got %b exp 00", err_code); end
   endtask

   task automatic test_basic();
      logic [1095:0] exp_str;
      int d0;
      exp_str = '0;
      exp_str[23:0] = 24'h434241;
      do_reset();
      d0 = done_cnt;
      send_byte(8'h26, 2);
      checks++; if (rx_busy !== 1'b1) begin failures++;
         $display("FAIL basic_busy_first got %b exp 1", rx_busy); end
      send_byte(8'h26, 2);
      send_byte(8'h41, 2);
      send_byte(8'h42, 2);
      send_byte(8'h43, 2);
      checks++; if (rx_busy !== 1'b1) begin failures++;
         $display("FAIL basic_busy_mid got %b exp 1", rx_busy); end
      send_byte(8'h26, 2);
      send_byte(8'h26, 2);
      checks++; if (rx_busy !== 1'b0) begin failures++;
         $display("FAIL basic_busy_end got %b exp 0", rx_busy); end
      checks++; if (done_cnt - d0 !== 1) begin failures++;
         $display("FAIL basic_done_count got %0d exp 1", done_cnt - d0); end
      checks++; if (done_len[d0 % 8] !== 3) begin failures++;
         $display("FAIL basic_len_at_done got %0d exp 3", done_len[d0 % 8]); end
      checks++; if (rx_string !== exp_str) begin failures++;
         $display("FAIL basic_string got %0h exp %0h", rx_string[63:0], exp_str[63:0]); end
   endtask

   task automatic test_embedded_amp();
      logic [7:0] seq [9];
      logic [1095:0] exp_str;
      int d0;
      seq = '{8'h78, 8'h79, 8'h26, 8'h26, 8'h41, 8'h26, 8'h42, 8'h26, 8'h26};
      exp_str = '0;
      exp_str[23:0] = 24'h422641;
      do_reset();
      d0 = done_cnt;
      for (int i = 0; i < 9; i++) send_byte(seq[i], 1);
      @(negedge sys_clk);
      checks++; if (done_cnt - d0 !== 1) begin failures++;
         $display("FAIL embed_done_count got %0d exp 1", done_cnt - d0); end
      checks++; if (rx_length !== 8'd3) begin failures++;
         $display("FAIL embed_len got %0d exp 3", rx_length); end
      checks++; if (rx_string !== exp_str) begin failures++;
         $display("FAIL embed_string got %0h exp %0h", rx_string[63:0], exp_str[63:0]); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq [9];
      int d0;
      seq = '{8'h26, 8'h26, 8'h26, 8'h26, 8'h26, 8'h26, 8'h5A, 8'h26, 8'h26};
      do_reset();
      d0 = done_cnt;
      for (int i = 0; i < 9; i++) send_byte(seq[i], 0);
      repeat (2) @(negedge sys_clk);
      checks++; if (done_cnt - d0 !== 2) begin failures++;
         $display("FAIL b2b_done_count got %0d exp 2", done_cnt - d0); end
      checks++; if (done_len[d0 % 8] !== 0) begin failures++;
         $display("FAIL b2b_len0 got %0d exp 0", done_len[d0 % 8]); end
      checks++; if (done_len[(d0 + 1) % 8] !== 1) begin failures++;
         $display("FAIL b2b_len1 got %0d exp 1", done_len[(d0 + 1) % 8]); end
      checks++; if (done_str[(d0 + 1) % 8] !== {1088'd0, 8'h5A}) begin failures++;
         $display("FAIL b2b_payload got %0h exp 5a", done_str[(d0 + 1) % 8][63:0]); end
   endtask

   task automatic test_overflow();
      logic [7:0] seq [7];
      int d0;
      int e0;
      seq = '{8'h26, 8'h26, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
      do_reset();
      d0 = done_cnt;
      e0 = err_cnt;
      for (int i = 0; i < 6; i++) send_byte(seq[i], 1);
      checks++; if (err_cnt - e0 !== 0) begin failures++;
         $display("FAIL ovf_early_err got %0d exp 0", err_cnt - e0); end
      send_byte(seq[6], 1);
      checks++; if (err_cnt - e0 !== 1) begin failures++;
         $display("FAIL ovf_err_count got %0d exp 1", err_cnt - e0); end
      checks++; if (err_code !== 2'b01) begin failures++;
         $display("FAIL ovf_err_code got %b exp 01", err_code); end
      checks++; if (rx_length !== 8'd4) begin failures++;
         $display("FAIL ovf_len got %0d exp 4", rx_length); end
      checks++; if (rx_string[39:0] !== 40'h0044434241) begin failures++;
         $display("FAIL ovf_string got %0h exp 44434241", rx_string[39:0]); end
      checks++; if (rx_busy !== 1'b0) begin failures++;
         $display("FAIL ovf_busy got %b exp 0", rx_busy); end
      // Trailing "&&" opens a new frame rather than completing one.
      send_byte(8'h26, 1);
      send_byte(8'h26, 1);
      checks++; if (rx_busy !== 1'b1 || done_cnt - d0 !== 0) begin failures++;
         $display("FAIL ovf_trailer got busy=%b dones=%0d exp 1 0", rx_busy, done_cnt - d0); end
      checks++; if (rx_length !== 8'd0 || err_code !== 2'b00) begin failures++;
         $display("FAIL ovf_reopen got len=%0d code=%b exp 0 00", rx_length, err_code); end
   endtask

   task automatic test_overflow_end1();
      logic [7:0] seq [7];
      int e0;
      seq = '{8'h26, 8'h26, 8'h41, 8'h42, 8'h43, 8'h26, 8'h44};
      do_reset();
      e0 = err_cnt;
      for (int i = 0; i < 7; i++) send_byte(seq[i], 1);
      checks++; if (err_cnt - e0 !== 1 || err_code !== 2'b01) begin failures++;
         $display("FAIL ovf_end1_err got errs=%0d code=%b exp 1 01", err_cnt - e0, err_code); end
      checks++; if (rx_length !== 8'd3 || rx_string[31:0] !== 32'h00434241) begin failures++;
         $display("FAIL ovf_end1_data got len=%0d str=%0h exp 3 434241",
                  rx_length, rx_string[31:0]); end
   endtask

   task automatic test_timeout();
      int e0;
      int found;
      do_reset();
      e0 = err_cnt;
      send_byte(8'h26, 0);
      send_byte(8'h26, 0);
      send_byte(8'h41, 0);
      send_byte(8'h42, 0);
      found = -1;
      for (int i = 0; i < 150; i++) begin
         @(negedge sys_clk);
         if (rx_err === 1'b1) begin
            found = i;
            break;
         end
      end
      checks++; if (found !== 99) begin failures++;
         $display("FAIL tmo_latency got %0d exp 99", found); end
      checks++; if (err_code !== 2'b10) begin failures++;
         $display("FAIL tmo_err_code got %b exp 10", err_code); end
      checks++; if (rx_length !== 8'd2 || rx_busy !== 1'b0) begin failures++;
         $display("FAIL tmo_state got len=%0d busy=%b exp 2 0", rx_length, rx_busy); end
      // Lone '&' then silence: quiet drop back to idle.
      do_reset();
      @(negedge sys_clk);
      e0 = err_cnt;
      send_byte(8'h26, 0);
      checks++; if (rx_busy !== 1'b1) begin failures++;
         $display("FAIL tmo_sign1_busy got %b exp 1", rx_busy); end
      repeat (150) @(negedge sys_clk);
      checks++; if (err_cnt - e0 !== 0 || rx_busy !== 1'b0 || err_code !== 2'b00) begin
         failures++;
         $display("FAIL tmo_sign1_silent got errs=%0d busy=%b code=%b exp 0 0 00",
                  err_cnt - e0, rx_busy, err_code); end
   endtask

   task automatic test_async_reset();
      logic [7:0] seq [5];
      int d0;
      int e0;
      seq = '{8'h26, 8'h26, 8'h51, 8'h26, 8'h26};
      do_reset();
      send_byte(8'h26, 1);
      send_byte(8'h26, 1);
      send_byte(8'h41, 1);
      send_byte(8'h42, 1);
      d0 = done_cnt;
      e0 = err_cnt;
      #2 sys_rst_n = 1'b0;
      #1;
      checks++; if (rx_busy !== 1'b0 || rx_length !== 8'd0 || rx_string !== '0 ||
                    err_code !== 2'b00) begin failures++;
         $display("FAIL arst_immediate got busy=%b len=%0d str=%0h code=%b exp 0 0 0 00",
                  rx_busy, rx_length, rx_string[63:0], err_code); end
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (3) @(negedge sys_clk);
      checks++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin failures++;
         $display("FAIL arst_no_pulse got dones=%0d errs=%0d exp 0 0",
                  done_cnt - d0, err_cnt - e0); end
      for (int i = 0; i < 5; i++) send_byte(seq[i], 1);
      checks++; if (done_cnt - d0 !== 1 || rx_length !== 8'd1) begin failures++;
         $display("FAIL arst_next_frame got dones=%0d len=%0d exp 1 1",
                  done_cnt - d0, rx_length); end
      checks++; if (rx_string !== {1088'd0, 8'h51}) begin failures++;
         $display("FAIL arst_payload got %0h exp 51", rx_string[63:0]); end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      done_cnt  = 0;
      err_cnt   = 0;
      rx_vld    = 1'b0;
      rx_byte   = 8'h00;
      sys_rst_n = 1'b0;
      test_reset();
      test_basic();
      test_embedded_amp();
      test_back_to_back();
      test_overflow();
      test_overflow_end1();
      test_timeout();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
